sram_1r1w_masked_init: RTL and testbench



---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_clear_seq.sv | 47 ++++
 rtl/sram_1r1w_masked_init.sv | 105 ++++++++++
 tb/tb_sram_1r1w_masked_init.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W masked SRAM model.
// Holds the FSM state enum, clog2 and the granule mask-merge function.
package sram_pkg;

    // Upper bound on entry width handled by the generic merge helper.
    localparam int SRAM_MAX_W = 1024;

    typedef enum logic {
        INIT,
        RUN
    } sram_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Granule i of the result comes from new_v when mask[i] is set,
    // otherwise from old_v.
    function automatic logic [SRAM_MAX_W-1:0] merge(
        input logic [SRAM_MAX_W-1:0] old_v,
        input logic [SRAM_MAX_W-1:0] new_v,
        input logic [SRAM_MAX_W-1:0] mask,
        input int                    gran
    );
        logic [SRAM_MAX_W-1:0] res;
        res = old_v;
        for (int i = 0; i < SRAM_MAX_W; i++) begin
            if (mask[i / gran]) begin
                res[i] = new_v[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sweep: walks every entry once, then raises ready.
// INIT writes one entry per cycle; RUN is the idle terminal state.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    sram_state_t       state;
    logic [ADDR_W-1:0] ptr;

    // Sweep pointer 0..DEPTH-1, leave INIT on the last clear write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (ptr == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == INIT);
    assign clr_addr = ptr;

endmodule

// File: rtl/sram_1r1w_masked_init.sv
// Simple-dual-port masked SRAM model with hardware clear after reset.
// Optional macro SRAM_WR_BYPASS_EN: same-address read sees merged write data.
module sram_1r1w_masked_init
    import sram_pkg::*;
#(
    parameter int               DEPTH     = 512,
    parameter int               WIDTH     = 64,
    parameter int               MASK_GRAN = 8,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    localparam int              ADDR_W    = clog2(DEPTH),
    localparam int              MASK_W    = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [WIDTH-1:0]  r_data,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [WIDTH-1:0]  w_data
);

    localparam int              PAD     = SRAM_MAX_W - WIDTH;
    localparam int              MPAD    = SRAM_MAX_W - MASK_W;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;
    logic                  w_ok;
    logic                  r_ok;
    logic                  w_go;
    logic                  r_go;
    logic [ADDR_W-1:0]     w_idx;
    logic [ADDR_W-1:0]     r_idx;
    logic [WIDTH-1:0]      w_old;
    logic [WIDTH-1:0]      r_old;
    logic [WIDTH-1:0]      w_merged;
    logic [WIDTH-1:0]      rd_val;
    logic [SRAM_MAX_W-1:0] merged_x;
    logic                  unused_hi;

    sram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clock    (clock),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Out-of-range addresses only exist for non-power-of-two depths.
    assign w_ok  = {1'b0, w_addr} < DEPTH_X;
    assign r_ok  = {1'b0, r_addr} < DEPTH_X;
    assign w_go  = ready & w_en & w_ok;
    assign r_go  = ready & r_en;
    assign w_idx = w_ok ? w_addr : '0;
    assign r_idx = r_ok ? r_addr : '0;
    assign w_old = mem[w_idx];
    assign r_old = mem[r_idx];

    assign merged_x = merge({{PAD{1'b0}}, w_old},
                            {{PAD{1'b0}}, w_data},
                            {{MPAD{1'b0}}, w_mask},
                            MASK_GRAN);
    assign w_merged  = merged_x[WIDTH-1:0];
    assign unused_hi = ^merged_x[SRAM_MAX_W-1:WIDTH];

`ifdef SRAM_WR_BYPASS_EN
    logic byp;
    assign byp    = w_go & (w_addr == r_addr);
    assign rd_val = !r_ok ? '0 : (byp ? w_merged : r_old);
`else
    assign rd_val = r_ok ? r_old : '0;
`endif

    // Array write: clear sweep owns the port until ready rises.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (w_go) begin
            mem[w_idx] <= w_merged;
        end
    end

    // Registered read data with hold; valid pulses one cycle per read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= r_go;
            if (r_go) begin
                r_data <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_sram_1r1w_masked_init.sv
// Directed bench for sram_1r1w_masked_init (DEPTH=5, 64-bit, byte mask).
// Expected values are hand-computed constants per vector.
module tb_sram_1r1w_masked_init;

    localparam int          DEPTH = 5;
    localparam int          WIDTH = 64;
    localparam int          AW    = 3;
    localparam logic [63:0] IV    = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clock;
    logic             reset;
    logic             ready;
    logic             r_en;
    logic [AW-1:0]    r_addr;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_en;
    logic [AW-1:0]    w_addr;
    logic [7:0]       w_mask;
    logic [WIDTH-1:0] w_data;

    int n_cmp;
    int n_bad;
    logic [63:0] exp_mem [DEPTH];

    sram_1r1w_masked_init #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (8),
        .INIT_VAL  (IV)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ready   (ready),
        .r_en    (r_en),
        .r_addr  (r_addr),
        .r_valid (r_valid),
        .r_data  (r_data),
        .w_en    (w_en),
        .w_addr  (w_addr),
        .w_mask  (w_mask),
        .w_data  (w_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [63:0] exp);
        r_en   = 1'b1;
        r_addr = a;
        tick();
        r_en = 1'b0;
        chk($sformatf("rvalid_a%0d", a), {63'd0, r_valid}, 64'd1);
        chk($sformatf("rdata_a%0d", a), r_data, exp);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d,
                            input logic [7:0] m);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        w_mask = m;
        tick();
        w_en = 1'b0;
    endtask

    task automatic check_sweep(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk($sformatf("%s_rv%0d", tag, k), {63'd0, r_valid}, 64'd0);
            if (k == DEPTH - 1)
                chk({tag, "_rdy_lo"}, {63'd0, ready}, 64'd0);
        end
        chk({tag, "_rdy_hi"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        r_en   = 1'b0;
        r_addr = '0;
        w_en   = 1'b0;
        w_addr = '0;
        w_mask = '0;
        w_data = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = IV;

        // reset state
        tick();
        tick();
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_rvalid", {63'd0, r_valid}, 64'd0);
        chk("rst_rdata", r_data, 64'd0);

        // 1: clear sweep, reads ignored during INIT
        reset = 1'b0;
        r_en  = 1'b1;
        w_en  = 1'b1;
        w_mask = 8'hFF;
        w_data = 64'd0;
        check_sweep("init");
        r_en = 1'b0;
        w_en = 1'b0;
        chk("init_rdata", r_data, 64'd0);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), IV);

        // 2: masked write low four bytes
        do_write(3'd3, 64'h1122_3344_5566_7788, 8'h0F);
        exp_mem[3] = 64'hA5A5_A5A5_5566_7788;
        do_read(3'd3, exp_mem[3]);

        // 3: read-data hold across a later write
        do_read(3'd2, IV);
        do_write(3'd2, 64'd0, 8'hFF);
        exp_mem[2] = 64'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_rv", {63'd0, r_valid}, 64'd0);
            chk("hold_rd", r_data, IV);
        end
        do_read(3'd2, 64'd0);

        // 4: same-cycle same-address read/write
        r_en   = 1'b1;
        r_addr = 3'd1;
        w_en   = 1'b1;
        w_addr = 3'd1;
        w_data = ONES;
        w_mask = 8'hFF;
        tick();
        r_en = 1'b0;
        w_en = 1'b0;
`ifdef SRAM_WR_BYPASS_EN
        chk("raw_same", r_data, ONES);
`else
        chk("raw_same", r_data, IV);
`endif
        exp_mem[1] = ONES;
        do_read(3'd1, ONES);

        // mask all-zero leaves entry untouched
        do_write(3'd4, 64'h0123_4567_89AB_CDEF, 8'h00);
        do_read(3'd4, IV);

        // 5: out-of-range read and write
        do_read(3'd6, 64'd0);
        do_write(3'd6, 64'd0, 8'hFF);
        do_write(3'd7, 64'd0, 8'hFF);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), exp_mem[i]);

        // 6: reset during a read issue cycle
        do_write(3'd0, 64'h1234, 8'hFF);
        do_write(3'd4, 64'h5678, 8'hFF);
        @(negedge clock);
        r_en   = 1'b1;
        r_addr = 3'd0;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", {63'd0, ready}, 64'd0);
        chk("mid_rst_rd", r_data, 64'd0);
        tick();
        chk("mid_rst_rv", {63'd0, r_valid}, 64'd0);
        r_en  = 1'b0;
        reset = 1'b0;
        check_sweep("reinit");
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), IV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
